// File: rtl/if_stage_prefetch.sv
`default_nettype none
// ============================================================================
// Module : if_stage_prefetch
// Brief  : Instruction fetch stage with a DEPTH-entry prefetch queue feeding ID.
// Rev    : 1.0  initial release
// ============================================================================
module if_stage_prefetch #(
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned PC_STEP    = 4,
    parameter logic [WORD_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          branch_taken,
    input  logic [WORD_WIDTH-1:0]         branch_addr,
    output logic                          imem_req,
    output logic [WORD_WIDTH-1:0]         imem_addr,
    input  logic [WORD_WIDTH-1:0]         imem_rdata,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WORD_WIDTH-1:0]         pc,
    output logic [WORD_WIDTH-1:0]         instruction,
    output logic [$clog2(DEPTH+1)-1:0]    count
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    localparam logic [WORD_WIDTH-1:0] c_pc_step     = WORD_WIDTH'(PC_STEP);
    localparam logic [CNT_W-1:0]      c_depth_cnt   = CNT_W'(DEPTH);
    localparam logic [CNT_W:0]        c_depth_ext   = (CNT_W + 1)'(DEPTH);

    logic [WORD_WIDTH-1:0] r_fetch_pc;
    logic                  r_inflight;
    logic [WORD_WIDTH-1:0] r_inflight_pc;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [WORD_WIDTH-1:0] r_q_pc    [DEPTH];
    logic [WORD_WIDTH-1:0] r_q_instr [DEPTH];

    logic w_live;
    logic w_credit;
    logic w_push;
    logic w_pop;

    // Credit counts the outstanding fetch so a response always finds a free slot.
    assign w_live   = !rst && !branch_taken;
    assign w_credit = ({1'b0, r_count} + (CNT_W + 1)'(r_inflight)) < c_depth_ext;
    assign w_push   = w_live && r_inflight;
    assign w_pop    = out_valid && out_ready;

    assign imem_req    = w_live && w_credit;
    assign imem_addr   = r_fetch_pc;
    assign out_valid   = w_live && (r_count != '0);
    assign pc          = out_valid ? r_q_pc[r_rd_ptr]    : '0;
    assign instruction = out_valid ? r_q_instr[r_rd_ptr] : '0;
    assign count       = r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
        end else if (branch_taken) begin
            r_fetch_pc <= branch_addr;
            r_inflight <= 1'b0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_inflight <= imem_req;
            if (imem_req) begin
                r_fetch_pc    <= r_fetch_pc + c_pc_step;
                r_inflight_pc <= r_fetch_pc;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_pc[r_wr_ptr]    <= r_inflight_pc;
            r_q_instr[r_wr_ptr] <= imem_rdata;
        end
    end

    a_count_bound : assert property (@(posedge clk) disable iff (rst) r_count <= c_depth_cnt);

endmodule
`default_nettype wire

// File: tb/tb_if_stage_prefetch.sv
`default_nettype none
// ============================================================================
// Module : tb_if_stage_prefetch
// Brief  : Directed and random checks of if_stage_prefetch against a queue model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_if_stage_prefetch;

    logic        clk;
    logic        rst;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic [2:0]  count;

    logic        w2_req;
    logic [31:0] w2_addr;
    logic [31:0] w2_rdata;
    logic        w2_valid;
    logic [31:0] w2_pc;
    logic [31:0] w2_instr;
    logic [2:0]  w2_count;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] mq[$];
    bit          m_infl;
    logic [31:0] m_infl_pc;
    logic [31:0] m_fpc;
    logic [31:0] delivered[$];
    logic [31:0] wrap_pc[$];
    logic [31:0] wrap_in[$];

    if_stage_prefetch u_dut (
        .clk(clk), .rst(rst), .branch_taken(branch_taken), .branch_addr(branch_addr),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .pc(pc),
        .instruction(instruction), .count(count)
    );

    if_stage_prefetch #(.RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
        .clk(clk), .rst(rst), .branch_taken(1'b0), .branch_addr(32'h0),
        .imem_req(w2_req), .imem_addr(w2_addr), .imem_rdata(w2_rdata),
        .out_valid(w2_valid), .out_ready(1'b1), .pc(w2_pc),
        .instruction(w2_instr), .count(w2_count)
    );

    always #5 clk = ~clk;

    // Memory returns ~addr one cycle after a request, junk otherwise.
    always @(posedge clk) begin
        imem_rdata <= imem_req ? ~imem_addr : $urandom;
        w2_rdata   <= w2_req   ? ~w2_addr   : $urandom;
    end

    always @(negedge clk) begin
        if (w2_valid && !rst) begin
            wrap_pc.push_back(w2_pc);
            wrap_in.push_back(w2_instr);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input logic [31:0] start);
        mq.delete();
        m_infl = 1'b0;
        m_fpc  = start;
    endtask

    // Compare every output to the model, then advance one clock.
    task automatic tick();
        bit          live;
        bit          issue;
        bit          r_rst;
        bit          r_bt;
        bit          r_rdy;
        logic [31:0] r_ba;
        #1;
        live  = !rst && !branch_taken;
        issue = live && (mq.size() + int'(m_infl) < 4);
        chk("imem_req", 32'(imem_req), 32'(issue));
        if (issue) chk("imem_addr", imem_addr, m_fpc);
        chk("out_valid", 32'(out_valid), 32'(live && mq.size() != 0));
        chk("pc", pc, (live && mq.size() != 0) ? mq[0] : 32'h0);
        chk("instruction", instruction, (live && mq.size() != 0) ? ~mq[0] : 32'h0);
        chk("count", 32'(count), 32'(mq.size()));
        if (out_valid && out_ready) delivered.push_back(pc);
        r_rst = rst;
        r_bt  = branch_taken;
        r_rdy = out_ready;
        r_ba  = branch_addr;
        @(posedge clk);
        if (r_rst) begin
            model_reset(32'h0);
        end else if (r_bt) begin
            model_reset(r_ba);
        end else begin
            if (mq.size() != 0 && r_rdy) void'(mq.pop_front());
            if (m_infl) mq.push_back(m_infl_pc);
            m_infl = issue;
            if (issue) begin
                m_infl_pc = m_fpc;
                m_fpc     = m_fpc + 32'd4;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        clk          = 1'b0;
        rst          = 1'b1;
        branch_taken = 1'b0;
        branch_addr  = 32'h0;
        out_ready    = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset(32'h0);
        rst = 1'b0;

        // Streaming from reset: first delivery two edges after first request.
        delivered.delete();
        repeat (8) tick();
        chk("t1_n", 32'(delivered.size()), 32'd6);
        for (int i = 0; i < 6 && i < delivered.size(); i++) chk("t1_pc", delivered[i], 32'(4 * i));

        // Wrap-around from RESET_PC near the top of the address space.
        chk("wrap_n", 32'(wrap_pc.size() >= 4), 32'd1);
        for (int i = 0; i < 4 && i < wrap_pc.size(); i++) begin
            chk("wrap_pc", wrap_pc[i], 32'hFFFF_FFF8 + 32'(4 * i));
            chk("wrap_instr", wrap_in[i], ~(32'hFFFF_FFF8 + 32'(4 * i)));
        end
        chk("wrap_count", 32'(w2_count <= 3'd4), 32'd1);

        // Stalled consumer: queue fills to DEPTH and fetching stops.
        out_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (7) tick();
        chk("t2_full", 32'(count), 32'd4);
        chk("t2_noreq", 32'(imem_req), 32'd0);
        delivered.delete();
        out_ready = 1'b1;
        repeat (5) tick();
        chk("t2_n", 32'(delivered.size()), 32'd5);
        for (int i = 0; i < 5 && i < delivered.size(); i++) chk("t2_pc", delivered[i], 32'(4 * i));

        // Flush with three queued entries plus one in flight.
        out_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (4) tick();
        chk("t3_cnt", 32'(count), 32'd3);
        branch_taken = 1'b1;
        branch_addr  = 32'h100;
        #1;
        chk("t3_bvalid", 32'(out_valid), 32'd0);
        chk("t3_breq", 32'(imem_req), 32'd0);
        tick();
        branch_taken = 1'b0;
        #1;
        chk("t3_cnt0", 32'(count), 32'd0);
        chk("t3_req", 32'(imem_req), 32'd1);
        chk("t3_addr", imem_addr, 32'h100);
        delivered.delete();
        out_ready = 1'b1;
        repeat (4) tick();
        chk("t3_n", 32'(delivered.size()), 32'd2);
        if (delivered.size() >= 2) begin
            chk("t3_pc0", delivered[0], 32'h100);
            chk("t3_pc1", delivered[1], 32'h104);
        end

        // Branch and ready together: nothing pops, queue flushed.
        out_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("t4_cnt", 32'(count), 32'd2);
        out_ready    = 1'b1;
        branch_taken = 1'b1;
        branch_addr  = 32'h200;
        #1;
        chk("t4_valid", 32'(out_valid), 32'd0);
        delivered.delete();
        tick();
        branch_taken = 1'b0;
        #1;
        chk("t4_cnt0", 32'(count), 32'd0);
        chk("t4_nopop", 32'(delivered.size()), 32'd0);
        repeat (4) tick();
        chk("t4_pc0", delivered.size() != 0 ? delivered[0] : 32'hDEAD_BEEF, 32'h200);

        // Single-cycle reset while a fetch is outstanding.
        repeat (5) tick();
        chk("t6_infl", 32'(m_infl), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        delivered.delete();
        repeat (4) tick();
        chk("t6_pc0", delivered.size() != 0 ? delivered[0] : 32'hDEAD_BEEF, 32'h0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            out_ready    = ($urandom_range(0, 3) != 0);
            branch_taken = ($urandom_range(0, 19) == 0);
            branch_addr  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
            rst          = ($urandom_range(0, 49) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
